// File: rtl/prim_cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prim_cipher_pkg
// Purpose  : Shared PRESENT cipher primitives: 4-bit S-box tables, bit
//            permutation tables, S-box/permutation layer helpers, the 80- and
//            128-bit key schedule steps (forward and inverse), and the state
//            encoding of the iterative PRESENT engine.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package prim_cipher_pkg;

  // Nibble k of the literal holds S(k).
  localparam logic [15:0][3:0] PRESENT_SBOX4     = 64'h2174_8fe3_da09_b65c;
  localparam logic [15:0][3:0] PRESENT_SBOX4_INV = 64'ha970_364b_d21c_8fe5;

  // Entry k is the destination bit position of source bit k.
  typedef logic [63:0][5:0] perm64_t;

  // PRESENT moves bit i to 16*i mod 63 (bit 63 stays put). The inverse table
  // is the same map read backwards, so both come from one generator.
  function automatic perm64_t present_gen_perm(input logic inv);
    perm64_t p;
    int      j;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      j = (i == 63) ? 63 : ((i * 16) % 63);
      if (inv) p[j] = 6'(i);
      else     p[i] = 6'(j);
    end
    return p;
  endfunction

  localparam perm64_t PRESENT_PERM64     = present_gen_perm(1'b0);
  localparam perm64_t PRESENT_PERM64_INV = present_gen_perm(1'b1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } present_iter_state_e;

  function automatic logic [63:0] sbox4_64bit(input logic [63:0] state_in,
                                              input logic [15:0][3:0] sbox4);
    logic [63:0] state_out;
    for (int k = 0; k < 16; k++) begin
      state_out[k*4 +: 4] = sbox4[state_in[k*4 +: 4]];
    end
    return state_out;
  endfunction

  function automatic logic [63:0] perm_64bit(input logic [63:0] state_in,
                                             input perm64_t perm);
    logic [63:0] state_out;
    state_out = '0;
    for (int k = 0; k < 64; k++) begin
      state_out[perm[k]] = state_in[k];
    end
    return state_out;
  endfunction

  // Rotate left by 61, S-box the top nibble, fold the round counter in.
  function automatic logic [79:0] present_update_key80(input logic [79:0] key_in,
                                                       input logic [4:0] round_idx);
    logic [79:0] key_out;
    key_out          = {key_in[18:0], key_in[79:19]};
    key_out[79:76]   = PRESENT_SBOX4[key_out[79:76]];
    key_out[19:15]   = key_out[19:15] ^ round_idx;
    return key_out;
  endfunction

  function automatic logic [79:0] present_inv_update_key80(input logic [79:0] key_in,
                                                           input logic [4:0] round_idx);
    logic [79:0] key_tmp;
    key_tmp          = key_in;
    key_tmp[19:15]   = key_tmp[19:15] ^ round_idx;
    key_tmp[79:76]   = PRESENT_SBOX4_INV[key_tmp[79:76]];
    return {key_tmp[60:0], key_tmp[79:61]};
  endfunction

  function automatic logic [127:0] present_update_key128(input logic [127:0] key_in,
                                                         input logic [4:0] round_idx);
    logic [127:0] key_out;
    key_out          = {key_in[66:0], key_in[127:67]};
    key_out[127:124] = PRESENT_SBOX4[key_out[127:124]];
    key_out[123:120] = PRESENT_SBOX4[key_out[123:120]];
    key_out[66:62]   = key_out[66:62] ^ round_idx;
    return key_out;
  endfunction

  function automatic logic [127:0] present_inv_update_key128(input logic [127:0] key_in,
                                                             input logic [4:0] round_idx);
    logic [127:0] key_tmp;
    key_tmp          = key_in;
    key_tmp[66:62]   = key_tmp[66:62] ^ round_idx;
    key_tmp[127:124] = PRESENT_SBOX4_INV[key_tmp[127:124]];
    key_tmp[123:120] = PRESENT_SBOX4_INV[key_tmp[123:120]];
    return {key_tmp[60:0], key_tmp[127:61]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/prim_present_round.sv
`default_nettype none
// ============================================================================
// Module   : prim_present_round
// Purpose  : One combinational PRESENT round plus one key-schedule step.
//            Encrypt: perm(sbox(data ^ Ktop)). Decrypt: invsbox(invperm(data
//            ^ Ktop)). Key step direction is chosen independently so the
//            forward schedule can run ahead of a decryption.
// Ports    : data_i    - round input state
//            key_i     - current round key register
//            idx_i     - round counter folded into the key step
//            dec_i     - 1 selects the inverse data round
//            key_inv_i - 1 selects the inverse key step
//            data_o    - round output state
//            key_o     - next key register value
// Revision : 1.0 - initial release
// ============================================================================
module prim_present_round
  import prim_cipher_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int KeyWidth  = 128
) (
  input  logic [DataWidth-1:0] data_i,
  input  logic [KeyWidth-1:0]  key_i,
  input  logic [4:0]           idx_i,
  input  logic                 dec_i,
  input  logic                 key_inv_i,
  output logic [DataWidth-1:0] data_o,
  output logic [KeyWidth-1:0]  key_o
);

  logic [DataWidth-1:0] w_mixed;
  logic [DataWidth-1:0] w_enc;
  logic [DataWidth-1:0] w_dec;

  // In the first decrypt round the key register holds the last round key, so
  // this XOR is the undo of the final whitening; no separate step needed.
  assign w_mixed = data_i ^ key_i[KeyWidth-1 -: DataWidth];
  assign w_enc   = perm_64bit(sbox4_64bit(w_mixed, PRESENT_SBOX4), PRESENT_PERM64);
  assign w_dec   = sbox4_64bit(perm_64bit(w_mixed, PRESENT_PERM64_INV), PRESENT_SBOX4_INV);
  assign data_o  = dec_i ? w_dec : w_enc;

  if (KeyWidth == 80) begin : g_key80
    assign key_o = key_inv_i ? present_inv_update_key80(key_i, idx_i)
                             : present_update_key80(key_i, idx_i);
  end else begin : g_key128
    assign key_o = key_inv_i ? present_inv_update_key128(key_i, idx_i)
                             : present_update_key128(key_i, idx_i);
  end

endmodule
`default_nettype wire

// File: rtl/prim_present_iter.sv
`default_nettype none
// ============================================================================
// Module   : prim_present_iter
// Purpose  : Iterative PRESENT engine, one round per cycle through a single
//            round instance. Decryption first runs the forward key schedule
//            to reach the last round key, then walks it back per round.
// Ports    : clk_i, rst_i (sync, active-high)
//            in_valid_i/in_ready_o  - request handshake (decrypt_i, data_i,
//                                     key_i sampled on handshake)
//            out_valid_o/out_ready_i- result handshake, data_o held stable
//            busy_o                 - engine not idle
// Revision : 1.0 - initial release
// ============================================================================
module prim_present_iter
  import prim_cipher_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int KeyWidth  = 128,
  parameter int NumRounds = 31
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 decrypt_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [KeyWidth-1:0]  key_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 busy_o
);

  if (DataWidth != 64) begin : g_bad_data_width
    $error("prim_present_iter: DataWidth must be 64");
  end
  if (KeyWidth != 80 && KeyWidth != 128) begin : g_bad_key_width
    $error("prim_present_iter: KeyWidth must be 80 or 128");
  end
  if (NumRounds < 1 || NumRounds > 31) begin : g_bad_num_rounds
    $error("prim_present_iter: NumRounds must be in 1..31");
  end

  localparam logic [4:0] LastIdx = 5'(NumRounds);

  present_iter_state_e state_q, state_d;

  logic [DataWidth-1:0] data_q;
  logic [KeyWidth-1:0]  key_q;
  logic [4:0]           idx_q;
  logic                 dec_q;
  logic [DataWidth-1:0] out_q;

  logic [DataWidth-1:0] w_round_data;
  logic [KeyWidth-1:0]  w_round_key;
  logic                 w_key_inv;
  logic                 w_last_round;

  // Only decrypt rounds step the schedule backwards; KEYEXP always goes forward.
  assign w_key_inv    = (state_q == ROUND) && dec_q;
  assign w_last_round = dec_q ? (idx_q == 5'd1) : (idx_q == LastIdx);

  prim_present_round #(
    .DataWidth (DataWidth),
    .KeyWidth  (KeyWidth)
  ) u_round (
    .data_i    (data_q),
    .key_i     (key_q),
    .idx_i     (idx_q),
    .dec_i     (dec_q),
    .key_inv_i (w_key_inv),
    .data_o    (w_round_data),
    .key_o     (w_round_key)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i)              state_d = decrypt_i ? KEYEXP : ROUND;
      KEYEXP:  if (idx_q == LastIdx)        state_d = ROUND;
      ROUND:   if (w_last_round)            state_d = DONE;
      DONE:    if (out_ready_i)             state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  // Outputs from registered state only (reset gates in_ready directly).
  always_comb begin
    in_ready_o  = (state_q == IDLE) && !rst_i;
    out_valid_o = (state_q == DONE);
    busy_o      = (state_q != IDLE);
  end

  assign data_o = out_q;

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      key_q  <= '0;
      idx_q  <= '0;
      dec_q  <= 1'b0;
      out_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            data_q <= data_i;
            key_q  <= key_i;
            dec_q  <= decrypt_i;
            idx_q  <= 5'd1;
          end
        end
        KEYEXP: begin
          key_q <= w_round_key;
          // Decrypt rounds start from the top index, so park it there.
          if (idx_q != LastIdx) idx_q <= idx_q + 5'd1;
        end
        ROUND: begin
          data_q <= w_round_data;
          key_q  <= w_round_key;
          if (w_last_round) begin
            // Encrypt: final whitening with K(N+1). Decrypt: key is back at K1.
            out_q <= w_round_data ^ w_round_key[KeyWidth-1 -: DataWidth];
          end else if (dec_q) begin
            idx_q <= idx_q - 5'd1;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prim_present_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_present_iter
// Purpose  : Directed self-checking bench. Three engines: 128-bit key / 31
//            rounds, 80-bit key / 31 rounds, 128-bit key / 4 rounds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prim_present_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        decrypt   [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        busy      [3];
  logic [63:0] din       [3];
  logic [63:0] dout      [3];
  logic [127:0] key128   [3];
  logic [79:0]  key80;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  prim_present_iter #(.DataWidth(64), .KeyWidth(128), .NumRounds(31)) u_dut128 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .decrypt_i(decrypt[0]), .data_i(din[0]), .key_i(key128[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .data_o(dout[0]), .busy_o(busy[0]));

  prim_present_iter #(.DataWidth(64), .KeyWidth(80), .NumRounds(31)) u_dut80 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .decrypt_i(decrypt[1]), .data_i(din[1]), .key_i(key80),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .data_o(dout[1]), .busy_o(busy[1]));

  prim_present_iter #(.DataWidth(64), .KeyWidth(128), .NumRounds(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .decrypt_i(decrypt[2]), .data_i(din[2]), .key_i(key128[2]),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .data_o(dout[2]), .busy_o(busy[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int u, input logic dec, input logic [63:0] d, input logic [127:0] k);
    decrypt[u] = dec;
    din[u]     = d;
    if (u == 1) key80 = k[79:0];
    else        key128[u] = k;
  endtask

  // One full transaction; called #1 after an edge with the unit idle.
  task automatic run(input int u, input logic dec, input logic [63:0] d,
                     input logic [127:0] k, output logic [63:0] res, output int lat);
    chk("in_ready_before_req", 64'(in_ready[u]), 64'd1);
    set_req(u, dec, d, k);
    in_valid[u] = 1'b1;
    tick();
    in_valid[u] = 1'b0;
    set_req(u, ~dec, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    lat = 0;
    while (!out_valid[u] && lat < 200) begin
      tick();
      lat++;
    end
    res = dout[u];
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    chk("in_ready_after_out_hs", 64'(in_ready[u]), 64'd1);
  endtask

  initial begin
    logic [63:0]  res, res2, held, pt;
    logic [127:0] k;
    int           lat;
    int           cyc, nacc, nres;
    logic         acc_now;
    int           acc_cyc [3];
    logic [63:0]  bres    [3];

    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      set_req(i, 1'b0, 64'd0, 128'd0);
    end
    rst = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready[0]), 64'd0);
    chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_data_o", dout[0], 64'd0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", 64'(in_ready[0]), 64'd1);

    // Known-answer vectors
    run(0, 1'b0, 64'd0, 128'd0, res, lat);
    chk("k128_zero_enc", res, 64'h96db702a2e6900af);
    chk("k128_enc_latency", 64'(lat), 64'd31);
    run(0, 1'b1, 64'h96db702a2e6900af, 128'd0, res, lat);
    chk("k128_zero_dec", res, 64'd0);
    chk("k128_dec_latency", 64'(lat), 64'd62);

    run(1, 1'b0, 64'd0, 128'd0, res, lat);
    chk("k80_zero_enc", res, 64'h5579c1387b228445);
    chk("k80_enc_latency", 64'(lat), 64'd31);
    run(1, 1'b1, 64'h5579c1387b228445, 128'd0, res, lat);
    chk("k80_zero_dec", res, 64'd0);
    chk("k80_dec_latency", 64'(lat), 64'd62);
    run(1, 1'b0, 64'd0, {48'd0, {80{1'b1}}}, res, lat);
    chk("k80_kff_p00", res, 64'he72c46c0f5945049);
    run(1, 1'b0, {64{1'b1}}, 128'd0, res, lat);
    chk("k80_k00_pff", res, 64'ha112ffc72f68417b);
    run(1, 1'b0, {64{1'b1}}, {48'd0, {80{1'b1}}}, res, lat);
    chk("k80_kff_pff", res, 64'h3333dcd3213210d2);
    run(1, 1'b1, 64'he72c46c0f5945049, {48'd0, {80{1'b1}}}, res, lat);
    chk("k80_kff_dec", res, 64'd0);

    // Random round trips on every configuration
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 6; i++) begin
        pt = {$urandom, $urandom};
        k  = {$urandom, $urandom, $urandom, $urandom};
        run(u, 1'b0, pt, k, res, lat);
        chk("rt_enc_latency", 64'(lat), (u == 2) ? 64'd4 : 64'd31);
        run(u, 1'b1, res, k, res2, lat);
        chk("rt_dec_latency", 64'(lat), (u == 2) ? 64'd8 : 64'd62);
        chk("rt_roundtrip", res2, pt);
      end
    end

    // Output held under back-pressure, input requests ignored
    set_req(0, 1'b0, 64'd0, 128'd0);
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 200) begin tick(); lat++; end
    held = dout[0];
    chk("hold_initial", held, 64'h96db702a2e6900af);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      set_req(0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      tick();
      chk("hold_data", dout[0], held);
      chk("hold_valid", 64'(out_valid[0]), 64'd1);
      chk("hold_in_ready", 64'(in_ready[0]), 64'd0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("release_in_ready", 64'(in_ready[0]), 64'd1);
    chk("release_busy", 64'(busy[0]), 64'd0);

    // Reset during ROUND cycle 5
    set_req(0, 1'b0, 64'h0123456789abcdef, 128'd5);
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    chk("midrst_data_o", dout[0], 64'd0);
    chk("midrst_in_ready", 64'(in_ready[0]), 64'd0);
    rst = 1'b0;
    tick();
    run(0, 1'b0, 64'd0, 128'd0, res, lat);
    chk("post_rst_enc", res, 64'h96db702a2e6900af);

    // Back-to-back with in_valid and out_ready held high
    set_req(1, 1'b0, 64'd0, 128'd0);
    in_valid[1] = 1'b1;
    out_ready[1] = 1'b1;
    cyc = 0; nacc = 0; nres = 0;
    while (nres < 3 && cyc < 300) begin
      acc_now = in_ready[1] && in_valid[1];
      if (out_valid[1]) begin bres[nres] = dout[1]; nres++; end
      tick();
      cyc++;
      if (acc_now) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc == 1)      set_req(1, 1'b0, {64{1'b1}}, 128'd0);
        else if (nacc == 2) set_req(1, 1'b0, 64'd0, {48'd0, {80{1'b1}}});
        else                in_valid[1] = 1'b0;
      end
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b0;
    chk("b2b_results_count", 64'(nres), 64'd3);
    chk("b2b_accept_count", 64'(nacc), 64'd3);
    if (nacc == 3) begin
      chk("b2b_interval_1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd33);
      chk("b2b_interval_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd33);
    end
    if (nres == 3) begin
      chk("b2b_res0", bres[0], 64'h5579c1387b228445);
      chk("b2b_res1", bres[1], 64'ha112ffc72f68417b);
      chk("b2b_res2", bres[2], 64'he72c46c0f5945049);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
